// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared state encoding and constants for the sdram port arbiter.
package sdram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    DONE
  } state_t;

  localparam int DW = 16;
  localparam logic [DW-1:0] DEADBEEF_RD = 16'hDEAD;

endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: combinational round-robin selector; the search starts one past last_grant.
module sdram_rr_pick #(
  parameter  int NPORTS = 3,
  localparam int IW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last_grant,
  output logic [IW-1:0]     grant,
  output logic              any_req
);

  always_comb begin
    logic        found;
    int unsigned idx;
    grant   = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      idx = (32'(last_grant) + i) % NPORTS;
      if (!found && req[idx[IW-1:0]]) begin
        grant = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram controller port among NPORTS req/ack requesters.
// Define SDRAM_ARBITER_TIMEOUT_EN to add a WAIT watchdog and the timeout_err pulse.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NPORTS  = 3,
  parameter int AW      = 27,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    req_we,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_din,
  input  logic [NPORTS*2-1:0]  req_wtbt,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        sd_addr,
  output logic [DW-1:0]        sd_din,
  output logic [1:0]           sd_wtbt,
  output logic                 sd_we,
  output logic                 sd_rd,
  input  logic                 sd_ready,
  input  logic [DW-1:0]        sd_dout
`ifdef SDRAM_ARBITER_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IW = $clog2(NPORTS);

  if (NPORTS < 2 || NPORTS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("sdram_arbiter: NPORTS must be 2..8 and TIMEOUT 1..65535");
  end

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          op_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_din;
  logic [1:0]    pick_wtbt;
  logic          pick_we;

`ifdef SDRAM_ARBITER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          expired;
  assign expired = (wait_cnt == CW'(TIMEOUT - 1));
`endif

  sdram_rr_pick #(
    .NPORTS (NPORTS)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  always_comb begin
    pick_addr = req_addr[int'(pick)*AW +: AW];
    pick_din  = req_din[int'(pick)*DW +: DW];
    pick_wtbt = req_wtbt[int'(pick)*2 +: 2];
    pick_we   = req_we[pick];
  end

  // Strobes are registered so they are high exactly while in ISSUE;
  // the DONE->IDLE->ISSUE path guarantees a low cycle before every rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= '0;
      op_we      <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_wtbt    <= '0;
      sd_we      <= 1'b0;
      sd_rd      <= 1'b0;
`ifdef SDRAM_ARBITER_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack   <= '0;
      sd_we <= 1'b0;
      sd_rd <= 1'b0;
`ifdef SDRAM_ARBITER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sd_ready && any_req) begin
            grant   <= pick;
            op_we   <= pick_we;
            sd_addr <= pick_addr;
            sd_din  <= pick_din;
            sd_wtbt <= pick_wtbt;
            sd_we   <= pick_we;
            sd_rd   <= !pick_we;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE:  state <= SETTLE;
        SETTLE: begin
          state <= WAIT;
`ifdef SDRAM_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
`ifdef SDRAM_ARBITER_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (!sd_ready && expired) begin
            rdata       <= DEADBEEF_RD;
            timeout_err <= 1'b1;
          end else if (sd_ready && !op_we) begin
            rdata <= sd_dout;
          end
          if (sd_ready || expired) begin
            ack[grant] <= 1'b1;
            busy       <= 1'b0;
            last_grant <= grant;
            state      <= DONE;
          end
`else
          if (sd_ready) begin
            if (!op_we) rdata <= sd_dout;
            ack[grant] <= 1'b1;
            busy       <= 1'b0;
            last_grant <= grant;
            state      <= DONE;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
